// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side redirect bus between the branch/trap requesters and pc_redirect_ctrl.
// The controller connects through the slave modport; requesters and the PC block use master.
interface pc_redirect_ctrl_if #(
  parameter int PC_SIZE = 32
);
  logic               fetch_ready;
  logic               br_valid;
  logic [PC_SIZE-1:0] br_target;
  logic               br_annul;
  logic               br_ready;
  logic               trap_valid;
  logic [PC_SIZE-1:0] trap_vector;
  logic               trap_ready;
  logic               pc_advance;
  logic               redirect_en;
  logic [PC_SIZE-1:0] redirect_target;
  logic               annul_out;
  logic               busy;

  modport master (
    output fetch_ready, br_valid, br_target, br_annul, trap_valid, trap_vector,
    input  br_ready, trap_ready, pc_advance, redirect_en, redirect_target,
           annul_out, busy
  );

  modport slave (
    input  fetch_ready, br_valid, br_target, br_annul, trap_valid, trap_vector,
    output br_ready, trap_ready, pc_advance, redirect_en, redirect_target,
           annul_out, busy
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC/nPC redirect sequencer: arbitrates delayed-branch and trap redirects for fetch.
// Optional REDIRECT_STATS_EN adds branch/trap/stall event counters.
//
// state      | meaning
// IDLE       | sequential fetch, accepting branch and trap requests
// BR_PEND    | branch latched, presenting target as next nPC on advance
// TRAP_REDIR | trap latched, presenting vector and squashing old nPC slot
// TRAP_DRAIN | one advance to pull vector into PC; branches ignored
module pc_redirect_ctrl #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               reset,
  pc_redirect_ctrl_if.slave  bus
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]        stat_br_cnt,
  output logic [31:0]        stat_trap_cnt,
  output logic [31:0]        stat_stall_cnt
`endif
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BR_PEND    = 2'd1;
  localparam logic [1:0] TRAP_REDIR = 2'd2;
  localparam logic [1:0] TRAP_DRAIN = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [PC_SIZE-1:0] tgt_reg;
  logic [PC_SIZE-1:0] tgt_nxt;
  logic               annul_reg;
  logic               annul_nxt;

  assign bus.pc_advance      = bus.fetch_ready;
  assign bus.redirect_target = tgt_reg;
  assign bus.busy            = (state != IDLE);

  always_comb begin
    state_nxt       = state;
    tgt_nxt         = tgt_reg;
    annul_nxt       = annul_reg;
    bus.br_ready    = 1'b0;
    bus.trap_ready  = 1'b1;
    bus.redirect_en = 1'b0;
    bus.annul_out   = 1'b0;
    case (state)
      IDLE: begin
        bus.br_ready = !bus.trap_valid;
        if (bus.trap_valid) begin
          tgt_nxt   = bus.trap_vector;
          state_nxt = TRAP_REDIR;
        end else if (bus.br_valid) begin
          tgt_nxt   = bus.br_target;
          annul_nxt = bus.br_annul;
          state_nxt = BR_PEND;
        end
      end
      BR_PEND: begin
        bus.redirect_en = 1'b1;
        bus.annul_out   = annul_reg;
        // a trap overrides the pending branch even on its advance cycle
        if (bus.trap_valid) begin
          tgt_nxt   = bus.trap_vector;
          state_nxt = TRAP_REDIR;
        end else if (bus.fetch_ready) begin
          state_nxt = IDLE;
        end
      end
      TRAP_REDIR: begin
        bus.redirect_en = 1'b1;
        bus.annul_out   = 1'b1;
        bus.trap_ready  = 1'b0;
        if (bus.fetch_ready) state_nxt = TRAP_DRAIN;
      end
      TRAP_DRAIN: begin
        if (bus.trap_valid) begin
          tgt_nxt   = bus.trap_vector;
          state_nxt = TRAP_REDIR;
        end else if (bus.fetch_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tgt_reg   <= '0;
      annul_reg <= 1'b0;
    end else begin
      state     <= state_nxt;
      tgt_reg   <= tgt_nxt;
      annul_reg <= annul_nxt;
    end
  end

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_cnt    <= '0;
      stat_trap_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (state == BR_PEND && bus.fetch_ready) stat_br_cnt <= stat_br_cnt + 32'd1;
      if (state == TRAP_REDIR && bus.fetch_ready) stat_trap_cnt <= stat_trap_cnt + 32'd1;
      if (state != IDLE && !bus.fetch_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector bench for pc_redirect_ctrl; build with REDIRECT_STATS_EN to also check counters.
module tb_pc_redirect_ctrl;
  localparam int PC_SIZE = 32;
  localparam int NVEC    = 28;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_redirect_ctrl_if #(.PC_SIZE(PC_SIZE)) bus ();

`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_br_cnt, stat_trap_cnt, stat_stall_cnt;
`endif

  pc_redirect_ctrl #(.PC_SIZE(PC_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_br_cnt    (stat_br_cnt),
    .stat_trap_cnt  (stat_trap_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  typedef struct {
    logic        rst, fr, bv;
    logic [31:0] bt;
    logic        ba, tv;
    logic [31:0] tvec;
    logic        e_br, e_tr, c_tr, e_ren;
    logic [31:0] e_tgt;
    logic        e_ann, e_busy;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(logic rst, logic fr, logic bv, logic [31:0] bt, logic ba,
                              logic tv, logic [31:0] tvec, logic e_br, logic e_tr,
                              logic c_tr, logic e_ren, logic [31:0] e_tgt, logic e_ann,
                              logic e_busy);
    vec_t v;
    v.rst = rst; v.fr = fr; v.bv = bv; v.bt = bt; v.ba = ba; v.tv = tv; v.tvec = tvec;
    v.e_br = e_br; v.e_tr = e_tr; v.c_tr = c_tr; v.e_ren = e_ren; v.e_tgt = e_tgt;
    v.e_ann = e_ann; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(logic rst, logic fr, logic bv, logic [31:0] bt, logic ba,
                       logic tv, logic [31:0] tvec);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.fetch_ready = fr;
    bus.br_valid    = bv;
    bus.br_target   = bt;
    bus.br_annul    = ba;
    bus.trap_valid  = tv;
    bus.trap_vector = tvec;
    @(negedge clk);
  endtask

  initial begin
    // rst fr bv bt ba tv tvec | br tr ctr ren tgt ann busy
    vecs[0]  = mk(1,1,0,0,0,0,0,               1,1,1,0,0,0,0);
    vecs[1]  = mk(0,1,0,0,0,0,0,               1,1,1,0,0,0,0);
    vecs[2]  = mk(0,1,1,32'h2000,0,0,0,        1,1,1,0,0,0,0);
    vecs[3]  = mk(0,1,0,0,0,0,0,               0,0,0,1,32'h2000,0,1);
    vecs[4]  = mk(0,1,0,0,0,0,0,               1,1,1,0,0,0,0);
    vecs[5]  = mk(0,0,1,32'h3000,1,0,0,        1,1,1,0,0,0,0);
    vecs[6]  = mk(0,0,0,0,0,0,0,               0,0,0,1,32'h3000,1,1);
    vecs[7]  = mk(0,0,0,0,0,0,0,               0,0,0,1,32'h3000,1,1);
    vecs[8]  = mk(0,0,0,0,0,0,0,               0,0,0,1,32'h3000,1,1);
    vecs[9]  = mk(0,1,0,0,0,0,0,               0,0,0,1,32'h3000,1,1);
    vecs[10] = mk(0,1,0,0,0,0,0,               1,1,1,0,0,0,0);
    vecs[11] = mk(0,1,1,32'h4000,0,1,32'h80,   0,1,1,0,0,0,0);
    vecs[12] = mk(0,1,1,32'h4000,0,0,0,        0,0,1,1,32'h80,1,1);
    vecs[13] = mk(0,0,1,32'h4000,0,0,0,        0,0,0,0,0,0,1);
    vecs[14] = mk(0,1,1,32'h4000,0,0,0,        0,0,0,0,0,0,1);
    vecs[15] = mk(0,0,1,32'h4000,0,0,0,        1,1,1,0,0,0,0);
    vecs[16] = mk(0,0,0,0,0,0,0,               0,0,0,1,32'h4000,0,1);
    vecs[17] = mk(0,0,0,0,0,1,32'h100,         0,1,1,1,32'h4000,0,1);
    vecs[18] = mk(0,0,0,0,0,0,0,               0,0,1,1,32'h100,1,1);
    vecs[19] = mk(1,1,0,0,0,0,0,               0,0,1,1,32'h100,1,1);
    vecs[20] = mk(0,1,0,0,0,0,0,               1,1,1,0,0,0,0);
    vecs[21] = mk(0,1,1,32'h6000,0,0,0,        1,1,1,0,0,0,0);
    vecs[22] = mk(0,1,0,0,0,1,32'h200,         0,1,1,1,32'h6000,0,1);
    vecs[23] = mk(0,1,0,0,0,0,0,               0,0,1,1,32'h200,1,1);
    vecs[24] = mk(0,1,0,0,0,1,32'hFFFF_FF00,   0,1,1,0,0,0,1);
    vecs[25] = mk(0,1,0,0,0,0,0,               0,0,1,1,32'hFFFF_FF00,1,1);
    vecs[26] = mk(0,1,0,0,0,0,0,               0,0,0,0,0,0,1);
    vecs[27] = mk(0,1,0,0,0,0,0,               1,1,1,0,0,0,0);

    reset = 1'b1;
    bus.fetch_ready = 1'b1; bus.br_valid = 1'b0; bus.br_target = '0; bus.br_annul = 1'b0;
    bus.trap_valid = 1'b0; bus.trap_vector = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].fr, vecs[i].bv, vecs[i].bt, vecs[i].ba,
            vecs[i].tv, vecs[i].tvec);
      chk("pc_advance", i, 32'(bus.pc_advance), 32'(vecs[i].fr));
      chk("br_ready", i, 32'(bus.br_ready), 32'(vecs[i].e_br));
      if (vecs[i].c_tr) chk("trap_ready", i, 32'(bus.trap_ready), 32'(vecs[i].e_tr));
      chk("redirect_en", i, 32'(bus.redirect_en), 32'(vecs[i].e_ren));
      if (vecs[i].e_ren) chk("redirect_target", i, bus.redirect_target, vecs[i].e_tgt);
      if (vecs[i].fr) chk("annul_out", i, 32'(bus.annul_out), 32'(vecs[i].e_ann));
      chk("busy", i, 32'(bus.busy), 32'(vecs[i].e_busy));
`ifdef REDIRECT_STATS_EN
      if (i == 20) begin
        chk("stat_br_cnt_rst", i, stat_br_cnt, 32'd0);
        chk("stat_trap_cnt_rst", i, stat_trap_cnt, 32'd0);
        chk("stat_stall_cnt_rst", i, stat_stall_cnt, 32'd0);
      end
`endif
    end

    // long stall on an annulling branch: target must hold, then advance returns to IDLE
    begin
`ifdef REDIRECT_STATS_EN
      logic [31:0] br0, tr0, st0;
      br0 = stat_br_cnt; tr0 = stat_trap_cnt; st0 = stat_stall_cnt;
`endif
      drive(0, 0, 1, 32'h7777_0000, 1, 0, 0);
      chk("seq_br_ready", 100, 32'(bus.br_ready), 32'd1);
      for (int k = 0; k < 5; k++) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("seq_stall_ren", 101 + k, 32'(bus.redirect_en), 32'd1);
        chk("seq_stall_tgt", 101 + k, bus.redirect_target, 32'h7777_0000);
      end
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("seq_adv_tgt", 106, bus.redirect_target, 32'h7777_0000);
      chk("seq_adv_annul", 106, 32'(bus.annul_out), 32'd1);
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("seq_idle_ren", 107, 32'(bus.redirect_en), 32'd0);
      chk("seq_idle_busy", 107, 32'(bus.busy), 32'd0);
`ifdef REDIRECT_STATS_EN
      chk("seq_stat_br", 107, stat_br_cnt - br0, 32'd1);
      chk("seq_stat_trap", 107, stat_trap_cnt - tr0, 32'd0);
      chk("seq_stat_stall", 107, stat_stall_cnt - st0, 32'd5);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences the PC/nPC next-instruction register pair for the fetch stage.
- Arbitrates control-flow redirects from the branch unit (delayed branch, optional delay-slot annul) and the trap unit.
- Drives the PC block's advance enable, redirect-mux select and redirect target, and flags squashed fetch slots to decode.

Parameters:
- PC_SIZE, 32, width of PC, nPC and all target/vector buses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_ready  in  1  fetch stage can accept a PC/nPC advance this cycle
- br_valid  in  1  branch unit requests redirect of nPC
- br_target  in  PC_SIZE  branch destination
- br_annul  in  1  delay-slot instruction must be squashed
- br_ready  out  1  branch request accepted this cycle
- trap_valid  in  1  trap unit requests redirect
- trap_vector  in  PC_SIZE  trap handler address
- trap_ready  out  1  trap request accepted this cycle
- pc_advance  out  1  advance enable to PC block
- redirect_en  out  1  PC block mux select: 1 = take redirect_target as next nPC
- redirect_target  out  PC_SIZE  redirect address
- annul_out  out  1  instruction entering PC on this advance is squashed
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on reset.
- Reset values:
  - state=IDLE; tgt_reg=0; annul_reg=0.
  - All outputs 0 except trap_ready=1 and br_ready=!trap_valid (IDLE values).
  - Reset mid-operation discards any latched redirect.
- pc_advance = fetch_ready, combinational. The PC block updates only on cycles with pc_advance=1 ("advance").
- Request capture is registered. The redirect is presented the cycle after acceptance, so minimum request-to-redirect latency is 1 cycle.
- States:
  - IDLE:
    - redirect_en=0, annul_out=0.
    - trap_valid=1: trap_ready=1, tgt_reg<=trap_vector, go TRAP_REDIR.
    - Else br_valid=1: br_ready=1, tgt_reg<=br_target, annul_reg<=br_annul, go BR_PEND.
    - br_ready = !trap_valid. On a simultaneous trap and branch, the trap wins and the branch is not accepted.
  - BR_PEND:
    - redirect_en=1, redirect_target=tgt_reg, annul_out=annul_reg, br_ready=0.
    - Advance: nPC<=tgt_reg, PC<=delay slot; annul_out marks the delay slot. Go IDLE.
    - No advance: hold all outputs stable.
    - trap_valid=1 (any cycle, including an advance cycle): trap_ready=1, branch dropped, tgt_reg<=trap_vector, go TRAP_REDIR.
  - TRAP_REDIR:
    - redirect_en=1, redirect_target=tgt_reg, annul_out=1, br_ready=0, trap_ready=0.
    - Advance: nPC<=vector, PC<=old nPC (squashed). Go TRAP_DRAIN.
    - No advance: hold.
  - TRAP_DRAIN:
    - redirect_en=0, annul_out=0, br_ready=0. br_valid is ignored, since branches from squashed slots must not redirect.
    - trap_valid=1: trap_ready=1, tgt_reg<=trap_vector, go TRAP_REDIR.
    - Else advance (PC<=vector, nPC<=vector+4 via normal path): go IDLE.
- annul_out and redirect_en are asserted only in BR_PEND/TRAP_REDIR. They are meaningful only when pc_advance=1.
- No arithmetic on targets; targets pass through unmodified, full PC_SIZE width.
- br_valid/trap_valid are level requests: the requester holds until its ready is seen high.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined: adds outputs stat_br_cnt, stat_trap_cnt and stat_stall_cnt, each 32 bits.
  - stat_br_cnt increments on each BR_PEND advance.
  - stat_trap_cnt increments on each TRAP_REDIR advance.
  - stat_stall_cnt increments each cycle with busy=1 && fetch_ready=0.
  - All counters are reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset with fetch_ready=1, then release -> state IDLE, redirect_en=0, annul_out=0, pc_advance=1, br_ready=1, trap_ready=1.
- br_valid=1, br_target=0x0000_2000, br_annul=0, fetch_ready=1 -> br_ready=1 that cycle. Next cycle redirect_en=1, redirect_target=0x2000, annul_out=0. Following cycle IDLE, redirect_en=0.
- Branch to 0x3000 with br_annul=1, fetch_ready=0 for 3 cycles then 1 -> redirect_en=1, target=0x3000 held stable 4 cycles. annul_out=1 on the advance cycle only.
- trap_valid=1 and br_valid=1 in the same IDLE cycle, trap_vector=0x0000_0080 -> trap_ready=1, br_ready=0. Next cycle redirect_en=1, target=0x80, annul_out=1. After the advance, TRAP_DRAIN with br_valid ignored, then IDLE.
- Trap at 0x0100 during BR_PEND (target 0x4000, stalled) -> redirect_target switches to 0x100 the next cycle; branch never presented.
- Reset asserted in TRAP_REDIR -> next cycle IDLE, redirect_en=0, annul_out=0. With REDIRECT_STATS_EN, all counters read 0.
